// File: rtl/gardner_timing_loop.sv
// Symbol-timing recovery loop: PI loop filter on Gardner TED errors driving a
// modulo-2^WACC phase-accumulator NCO that emits the symbol strobe and mu.
module gardner_timing_loop #(
  parameter int OSF    = 20,
  parameter int WERR   = 18,
  parameter int WACC   = 32,
  parameter int WMU    = 16,
  parameter int KP_SHL = 8,
  parameter int KI_SHL = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable_i,
  input  logic signed [WERR-1:0] e_in,
  input  logic                   e_valid_i,
  output logic                   sym_valid_o,
  output logic [WMU-1:0]         mu_o,
  output logic signed [WACC-1:0] ctrl_o,
  output logic                   integ_sat_o
);

  localparam int WS = WACC + 2;
  localparam int MW = WACC + $clog2(OSF + 1);
  localparam logic [63:0] NOM64 = ((64'd1 << WACC) + 64'(OSF / 2)) / 64'(OSF);
  localparam logic [WACC-1:0] NOM = WACC'(NOM64);
  localparam logic [WACC-1:0] CTRL_LIM = NOM >> 2;
  localparam logic signed [WS-1:0] LIM_S = signed'(WS'(CTRL_LIM));
  localparam logic signed [WACC-1:0] LIM_W = signed'(CTRL_LIM);
  localparam logic [WMU-1:0] MU_MAX = '1;

  function automatic logic signed [WS-1:0] sat_lim(input logic signed [WS-1:0] x);
    if (x > LIM_S) return LIM_S;
    else if (x < -LIM_S) return -LIM_S;
    else return x;
  endfunction

  logic [WACC-1:0]        phase_q, phase_d;
  logic signed [WACC-1:0] integ_q, integ_d;
  logic signed [WACC-1:0] ctrl_q, ctrl_d;
  logic                   sym_q, sym_d;
  logic [WMU-1:0]         mu_q, mu_d;
  logic                   sat_q, sat_d;

  logic signed [WS-1:0]   e_ext, inc, prop, integ_new, ctrl_new;
  logic [WACC-1:0]        step;
  logic [WACC:0]          acc_sum;
  logic [MW-1:0]          prod, frac;
  logic [WMU-1:0]         mu_calc;

  always_comb begin
    e_ext     = WS'(e_in);
    inc       = e_ext <<< KI_SHL;
    prop      = e_ext <<< KP_SHL;
    integ_new = sat_lim(WS'(integ_q) + inc);
    ctrl_new  = sat_lim(integ_new + prop);

    // ctrl_q is bounded by +/-CTRL_LIM, so the step is always positive
    step      = NOM - $unsigned(ctrl_q);
    acc_sum   = {1'b0, phase_q} + {1'b0, step};
    prod      = MW'(acc_sum[WACC-1:0]) * MW'(unsigned'(OSF));
    frac      = prod >> (WACC - WMU);
    mu_calc   = (frac > MW'(MU_MAX)) ? MU_MAX : WMU'(frac);

    phase_d = phase_q;
    integ_d = integ_q;
    ctrl_d  = ctrl_q;
    sym_d   = 1'b0;
    mu_d    = mu_q;
    if (enable_i) begin
      phase_d = acc_sum[WACC-1:0];
      sym_d   = acc_sum[WACC];
      if (acc_sum[WACC]) mu_d = mu_calc;
      if (e_valid_i) begin
        integ_d = WACC'(integ_new);
        ctrl_d  = WACC'(ctrl_new);
      end
    end
    sat_d = (integ_d == LIM_W) || (integ_d == -LIM_W);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q <= '0;
      integ_q <= '0;
      ctrl_q  <= '0;
      sym_q   <= 1'b0;
      mu_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      integ_q <= integ_d;
      ctrl_q  <= ctrl_d;
      sym_q   <= sym_d;
      mu_q    <= mu_d;
      sat_q   <= sat_d;
    end
  end

  assign sym_valid_o = sym_q;
  assign mu_o        = mu_q;
  assign ctrl_o      = ctrl_q;
  assign integ_sat_o = sat_q;

endmodule

// File: tb/tb_gardner_timing_loop.sv
// Randomised and directed bench for gardner_timing_loop: an arithmetic model
// predicts strobes into a queue that a separate monitor drains and checks.
module tb_gardner_timing_loop;
  localparam int OSF = 20;
  localparam int WERR = 18;
  localparam int WACC = 32;
  localparam int WMU = 16;
  localparam longint NOM = 214748365;
  localparam longint LIM = 53687091;
  localparam longint MODV = 64'sd1 <<< 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable_i = 1'b0;
  logic signed [WERR-1:0] e_in = '0;
  logic e_valid_i = 1'b0;
  logic sym_valid_o;
  logic [WMU-1:0] mu_o;
  logic signed [WACC-1:0] ctrl_o;
  logic integ_sat_o;

  gardner_timing_loop dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .e_in(e_in),
    .e_valid_i(e_valid_i), .sym_valid_o(sym_valid_o), .mu_o(mu_o),
    .ctrl_o(ctrl_o), .integ_sat_o(integ_sat_o)
  );

  always #5 clk = ~clk;

  typedef struct { int edge_n; longint mu; } strobe_t;
  strobe_t exp_q[$];
  int edge_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // reference model state (phase as a fraction of one symbol times 2^32)
  longint m_phase = 0, m_integ = 0, m_ctrl = 0, m_mu = 0;
  bit m_sat = 0, m_last_wrap = 0;

  function automatic longint satl(longint x);
    if (x > LIM) return LIM;
    if (x < -LIM) return -LIM;
    return x;
  endfunction

  function automatic bit will_wrap();
    return (m_phase + NOM - m_ctrl) >= MODV;
  endfunction

  task automatic cmp(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic cmp_range(string name, longint act, longint lo, longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // one clock: check held outputs, drive inputs, advance model for the next edge
  task automatic cyc(bit rst_n, bit en, bit ev, longint e);
    longint nxt;
    bit wrap;
    @(negedge clk);
    cmp("ctrl_o", ctrl_o, m_ctrl);
    cmp("integ_sat_o", integ_sat_o, m_sat);
    cmp("mu_o", mu_o, m_mu);
    reset_n = rst_n; enable_i = en; e_valid_i = ev; e_in = WERR'(e);
    wrap = 0;
    if (!rst_n) begin
      m_phase = 0; m_integ = 0; m_ctrl = 0; m_mu = 0; m_sat = 0;
    end else if (en) begin
      nxt = m_phase + (NOM - m_ctrl);
      wrap = (nxt >= MODV);
      m_phase = nxt % MODV;
      if (wrap) begin
        m_mu = (m_phase * OSF) >> (WACC - WMU);
        if (m_mu > 65535) m_mu = 65535;
        exp_q.push_back('{edge_n: edge_cnt + 1, mu: m_mu});
      end
      if (ev) begin
        m_integ = satl(m_integ + e);
        m_ctrl = satl(m_integ + e * 256);
        m_sat = (m_integ == LIM) || (m_integ == -LIM);
      end
    end
    m_last_wrap = wrap;
  endtask

  // monitor: pop a prediction on every DUT strobe
  initial forever begin
    @(posedge clk);
    #1;
    while (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
      n_cmp++; n_bad++;
      $display("FAIL strobe_missing: got none at edge %0d, required strobe", exp_q[0].edge_n);
      void'(exp_q.pop_front());
    end
    if (sym_valid_o) begin
      if (exp_q.size() > 0 && exp_q[0].edge_n == edge_cnt) begin
        strobe_t s;
        s = exp_q.pop_front();
        cmp("strobe_mu", mu_o, s.mu);
      end else begin
        n_cmp++; n_bad++;
        $display("FAIL strobe_unexpected: got strobe at edge %0d, required none", edge_cnt);
      end
    end
  end

  task automatic sat_run(longint e, int pmin, int pmax, longint ctrl_req);
    int n_err, sat_at, last_sv, guard;
    bit ev;
    n_err = 0; sat_at = 0; last_sv = -1; guard = 0;
    cyc(0, 0, 0, 0);
    while (n_err < 460 && guard < 20000) begin
      ev = m_last_wrap;
      cyc(1, 1, ev, e);
      guard++;
      if (integ_sat_o && sat_at == 0) sat_at = n_err;
      if (sym_valid_o) begin
        if (n_err >= 420 && last_sv >= 0) cmp_range("sat_period", edge_cnt - last_sv, pmin, pmax);
        last_sv = edge_cnt;
      end
      if (ev) n_err++;
    end
    cmp("sat_error_count", sat_at, 410);
    cmp("sat_ctrl", ctrl_o, ctrl_req);
  endtask

  initial begin
    int first;
    bit ev, en;
    repeat (3) cyc(0, 0, 0, 0);
    cmp("reset_sym_valid", sym_valid_o, 0);

    repeat (70) cyc(1, 1, 0, 0);

    cyc(1, 1, 1, 1000);
    @(posedge clk); #1;
    cmp("ctrl_single_err", ctrl_o, 257000);
    cyc(1, 1, 1, 0);
    @(posedge clk); #1;
    cmp("ctrl_after_zero", ctrl_o, 1000);
    repeat (30) cyc(1, 1, 0, 0);

    cyc(0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(30) != 0);
      if (will_wrap() && $urandom_range(1) == 1) ev = 1;
      else ev = ($urandom_range(15) == 0);
      cyc(1, en, ev, longint'($urandom_range(40000)) - 20000);
    end

    sat_run(131071, 26, 27, LIM);
    sat_run(-131072, 16, 17, -LIM);

    // freeze mid-symbol with error pulses while disabled
    first = 0;
    while (!m_last_wrap && first < 40) begin cyc(1, 1, 0, 0); first++; end
    repeat (8) cyc(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, i[0], 5000);
    @(posedge clk); #1;
    cmp("ctrl_after_disable", ctrl_o, -LIM);
    repeat (40) cyc(1, 1, 0, 0);

    // one-cycle reset with the integrator saturated
    cmp("pre_reset_sat", integ_sat_o, 1);
    cyc(0, 1, 1, -131072);
    @(posedge clk); #1;
    cmp("rst_ctrl", ctrl_o, 0);
    cmp("rst_mu", mu_o, 0);
    cmp("rst_sym", sym_valid_o, 0);
    cmp("rst_sat", integ_sat_o, 0);
    first = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, 0, 0);
      if (sym_valid_o) begin first = i; break; end
    end
    cmp("post_reset_strobe", first, 20);

    repeat (3) cyc(1, 0, 0, 0);
    @(posedge clk); #2;
    cmp("pending_strobes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
